sprite_line_reader: RTL
=======================

Name: sprite_line_reader

Overview:
- Composer-side reader for the double-buffered sprite line buffer.
- Owns buffer selection: drives active_render_buffer and flips it at each line start.
- On each pixel strobe, fetches one entry through the composer read port with fractional horizontal scaling, and delivers decoded sprite pixels to the compositor at a fixed latency.
- After a line completes, requests erase of the buffer it just read and reports the accumulated sprite collision mask.

Parameters:
- IDX_W, 10, line buffer index width.
- FRAC_W, 7, fractional bits of the scale accumulator (hscale 128 = 1.0).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- line_start  input  1  one-cycle pulse at the start of each visible line
- active_width  input  10  pixels per line; sampled at line_start
- hscale  input  8  per-pixel index increment, 1.7 fixed point; sampled at line_start
- pixel_strobe  input  1  request the next pixel
- active_render_buffer  output  1  buffer owned by the renderer
- composer_rd_idx  output  10  read index into the composer-side buffer
- composer_rd_data  input  16  read data, valid 1 clk after composer_rd_idx changes
- composer_erase_start  output  1  one-cycle erase request
- pixel_valid  output  1  pixel outputs valid this cycle
- pixel_color  output  8  composer_rd_data[7:0]
- pixel_z  output  2  composer_rd_data[13:12]
- line_collision  output  4  OR of composer_rd_data[11:8] over the line
- line_collision_valid  output  1  one-cycle pulse
- line_overrun  output  1  one-cycle pulse when a line is aborted

Behaviour:
- Reset (rst low, asynchronous):
  - state IDLE.
  - All outputs 0: active_render_buffer, composer_rd_idx, composer_erase_start, pixel_valid, pixel_color, pixel_z, line_collision, line_collision_valid, line_overrun.
  - Accumulator, counter and collision OR cleared; pipeline valids cleared.
  - Reset mid-line discards the line and issues no erase.
- Accumulator pos: IDX_W+FRAC_W = 17 bits. composer_rd_idx = pos[16:7], registered.
- States: IDLE, ACTIVE, DRAIN, ERASE.
- line_start in any state:
  - toggle active_render_buffer;
  - pos <= 0; cnt <= 0; collision OR <= 0;
  - latch active_width and hscale;
  - go to ACTIVE, or to DRAIN if active_width == 0.
- line_start in ACTIVE or DRAIN additionally pulses line_overrun and discards in-flight pixels: pipeline valids cleared, no collision report, no erase.
- line_start in ERASE still issues that cycle's erase pulse.
- ACTIVE, on pixel_strobe:
  - composer_rd_idx <= pos[16:7]; pos <= pos + hscale (mod 2^17, index wraps 1023 -> 0); cnt <= cnt + 1.
  - When cnt+1 == active_width, go to DRAIN.
  - Strobes in IDLE, DRAIN and ERASE are ignored.
- Pipeline:
  - Strobe at edge E: composer_rd_idx updates at E.
  - composer_rd_data is valid after E+1.
  - Output registers capture at E+2. pixel_valid is high for exactly one cycle (E+2 to E+3) per accepted strobe.
  - Fixed latency 2 clk; back-to-back strobes give back-to-back pixels.
  - pixel_color and pixel_z hold their last value when pixel_valid is low.
  - The collision OR accumulates at each pixel_valid.
- DRAIN: wait until the pipeline is empty, then:
  - pulse line_collision_valid with line_collision = accumulated OR;
  - go to ERASE.
- ERASE: pulse composer_erase_start for 1 cycle, then go to IDLE.
- Erase occupies the composer buffer for 160 clk. Callers keep ≥161 clk between ERASE and the next line_start; this block does not check it.
- hscale == 0 is legal: every pixel reads index 0.

Test Plan:
- Reset released, no stimulus -> all outputs 0, state IDLE; strobes produce no pixel_valid.
- line_start, width=4, hscale=128, four consecutive strobes, buffer data = idx+0x1000 -> active_render_buffer=1; rd_idx 0,1,2,3; pixel_valid 2 clk after each strobe with colors 0x00..0x03 and pixel_z=1; then line_collision_valid, then composer_erase_start 1 cycle.
- width=6, hscale=64, strobes with gaps -> rd_idx 0,0,1,1,2,2; each pixel exactly 2 clk after its strobe; no extra pixel_valid.
- Data collision nibbles 0x1,0x4,0x0 over 3 pixels -> line_collision=0x5 pulsed once at line end.
- line_start after 3 of 8 strobes -> line_overrun pulse; active_render_buffer toggles; no erase or collision pulse; pos restarts at 0; next line behaves normally.
- hscale=255, width=1024 -> index wraps past 1023 without stalling; width=0 -> line_collision_valid=0x0 then erase with no pixels; rst low mid-ACTIVE -> outputs 0 immediately, no erase.

Source files
------------

// File: rtl/sprite_line_reader.sv
// sprite_line_reader
//
// Composer-side reader for the double-buffered sprite line buffer. It owns
// buffer selection by flipping active_render_buffer on every line start. On
// each pixel strobe it issues one read of the line buffer at a horizontally
// scaled index. It delivers the decoded pixel two clocks after the strobe.
// When the line is done it reports the OR of all collision nibbles seen and
// asks for the buffer it just read to be erased.
//
// Ports
//   clk                  : clock
//   rst                  : asynchronous, active-low reset
//   line_start           : one-cycle pulse at the start of each visible line
//   active_width         : pixels per line, sampled at line_start
//   hscale               : per-pixel index increment, 1.7 fixed point
//   pixel_strobe         : request the next pixel
//   active_render_buffer : buffer currently owned by the renderer
//   composer_rd_idx      : read index into the composer-side buffer
//   composer_rd_data     : read data, valid one clock after the index changes
//   composer_erase_start : one-cycle erase request for the buffer just read
//   pixel_valid          : pixel_color / pixel_z are valid this cycle
//   pixel_color          : composer_rd_data[7:0]
//   pixel_z              : composer_rd_data[13:12]
//   line_collision       : OR of composer_rd_data[11:8] over the line
//   line_collision_valid : one-cycle pulse when line_collision is updated
//   line_overrun         : one-cycle pulse when a line is aborted
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no line in progress, strobes ignored
// ACTIVE | accepting strobes until active_width pixels have been requested
// DRAIN  | all pixels requested, waiting for the read pipeline to empty
// ERASE  | collision reported, issuing the erase request for this buffer

module sprite_line_reader #(
    parameter int IDX_W  = 10,
    parameter int FRAC_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             line_start,
    input  logic [IDX_W-1:0] active_width,
    input  logic [7:0]       hscale,
    input  logic             pixel_strobe,
    output logic             active_render_buffer,
    output logic [IDX_W-1:0] composer_rd_idx,
    input  logic [15:0]      composer_rd_data,
    output logic             composer_erase_start,
    output logic             pixel_valid,
    output logic [7:0]       pixel_color,
    output logic [1:0]       pixel_z,
    output logic [3:0]       line_collision,
    output logic             line_collision_valid,
    output logic             line_overrun
);

    localparam int POS_W = IDX_W + FRAC_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_ERASE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [POS_W-1:0] pos_q;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] width_q;
    logic [7:0]       hscale_q;
    logic [3:0]       coll_q;

    // Read pipeline: rd_pend marks an index issued last edge (RAM reading),
    // data_pend marks composer_rd_data holding a pixel to capture.
    logic rd_pend_q;
    logic data_pend_q;

    logic [IDX_W:0] cnt_inc;
    logic           last_pixel;
    logic           accept;
    logic           pipe_busy;
    logic           report;
    logic           overrun;
    logic           erase_now;

    // Bits 15:14 of the line-buffer word carry nothing this block uses.
    logic unused_rd_bits;
    assign unused_rd_bits = ^composer_rd_data[15:14];

    assign cnt_inc    = {1'b0, cnt_q} + {{IDX_W{1'b0}}, 1'b1};
    assign last_pixel = (cnt_inc == {1'b0, width_q});
    assign pipe_busy  = rd_pend_q | data_pend_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // line_start overrides everything, including a strobe in the same cycle.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        report    = 1'b0;
        overrun   = 1'b0;
        erase_now = (state_q == ST_ERASE);
        if (line_start) begin
            overrun = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);
            state_d = (active_width == '0) ? ST_DRAIN : ST_ACTIVE;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    accept = pixel_strobe;
                    if (pixel_strobe && last_pixel) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!pipe_busy) begin
                        report  = 1'b1;
                        state_d = ST_ERASE;
                    end
                end
                ST_ERASE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_render_buffer <= 1'b0;
            composer_rd_idx      <= '0;
            composer_erase_start <= 1'b0;
            pixel_valid          <= 1'b0;
            pixel_color          <= '0;
            pixel_z              <= '0;
            line_collision       <= '0;
            line_collision_valid <= 1'b0;
            line_overrun         <= 1'b0;
            pos_q                <= '0;
            cnt_q                <= '0;
            width_q              <= '0;
            hscale_q             <= '0;
            coll_q               <= '0;
            rd_pend_q            <= 1'b0;
            data_pend_q          <= 1'b0;
        end else begin
            line_overrun         <= overrun;
            line_collision_valid <= report;
            composer_erase_start <= erase_now;

            rd_pend_q   <= accept;
            data_pend_q <= rd_pend_q;
            pixel_valid <= data_pend_q;

            if (data_pend_q) begin
                pixel_color <= composer_rd_data[7:0];
                pixel_z     <= composer_rd_data[13:12];
                coll_q      <= coll_q | composer_rd_data[11:8];
            end

            if (accept) begin
                composer_rd_idx <= pos_q[POS_W-1:FRAC_W];
                pos_q           <= pos_q + {{(POS_W-8){1'b0}}, hscale_q};
                cnt_q           <= cnt_inc[IDX_W-1:0];
            end

            if (report) begin
                line_collision <= coll_q;
            end

            // A new line discards whatever the old one still had in flight.
            if (line_start) begin
                active_render_buffer <= ~active_render_buffer;
                pos_q                <= '0;
                cnt_q                <= '0;
                coll_q               <= '0;
                width_q              <= active_width;
                hscale_q             <= hscale;
                rd_pend_q            <= 1'b0;
                data_pend_q          <= 1'b0;
                pixel_valid          <= 1'b0;
                pixel_color          <= pixel_color;
                pixel_z              <= pixel_z;
            end
        end
    end

endmodule
